// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the CPU memory stage and an
// external loader/debug port, and steers registered read data back to the issuer.
module data_mem_arbiter #(
    parameter int DW         = 16,
    parameter int AW         = 16,
    parameter int DEPTH      = 100,
    parameter int STARVE_MAX = 4,
    parameter int SW         = $clog2(STARVE_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_w,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          stall,
    input  logic          ext_req,
    input  logic          ext_w,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ready,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          err,
    output logic          mem_en,
    output logic          mem_w,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          dbg_resp_state,
    output logic [SW-1:0] dbg_starve_cnt
);

    localparam logic [AW-1:0] DEPTH_A    = AW'(DEPTH);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} resp_state_t;

    resp_state_t   state, state_nxt;
    logic [SW-1:0] starve_cnt;
    logic          ext_win, cpu_win, grant, win_w, in_range, load_acc;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          owner_ext, oor_q, err_q;
    logic [DW-1:0] cpu_hold, ext_hold, resp_data;

    // Handshake: a request is accepted on the rising edge where req && ready;
    // until then the requester keeps req high and may change its fields.
    always_comb begin
        ext_win   = rst_n && ext_req && (!cpu_req || starve_cnt == STARVE_TOP);
        cpu_win   = rst_n && cpu_req && !ext_win;
        grant     = ext_win || cpu_win;
        win_w     = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        if (ext_win) begin
            win_w     = ext_w;
            win_addr  = ext_addr;
            win_wdata = ext_wdata;
        end else if (cpu_win) begin
            win_w     = cpu_w;
            win_addr  = cpu_addr;
            win_wdata = cpu_wdata;
        end
        in_range = win_addr < DEPTH_A;
        load_acc = grant && !win_w;
    end

    assign cpu_ready = cpu_win;
    assign ext_ready = ext_win;
    assign stall     = rst_n && cpu_req && !cpu_win;
    assign mem_en    = grant && in_range;
    assign mem_w     = win_w;
    assign mem_addr  = win_addr;
    assign mem_wdata = win_wdata;

    // Counts consecutive cycles the external port was kept waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!ext_req || ext_win) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_TOP) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_ext <= 1'b0;
            oor_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= grant && !in_range;
            if (load_acc) begin
                owner_ext <= ext_win;
                oor_q     <= !in_range;
            end
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = load_acc ? RESP : IDLE;
            RESP:    state_nxt = load_acc ? RESP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_rvalid = 1'b0;
        ext_rvalid = 1'b0;
        resp_data  = oor_q ? '0 : mem_rdata;
        if (state == RESP) begin
            if (owner_ext) ext_rvalid = 1'b1;
            else           cpu_rvalid = 1'b1;
        end
        cpu_rdata = cpu_rvalid ? resp_data : cpu_hold;
        ext_rdata = ext_rvalid ? resp_data : ext_hold;
    end

    // Each port keeps showing its last returned word between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_hold <= '0;
            ext_hold <= '0;
        end else begin
            if (cpu_rvalid) cpu_hold <= resp_data;
            if (ext_rvalid) ext_hold <= resp_data;
        end
    end

    assign err            = err_q;
    assign dbg_resp_state = (state == RESP);
    assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios followed by
// random traffic, checked against a reference model and response scoreboard.
module tb_data_mem_arbiter;

    localparam int DW         = 16;
    localparam int AW         = 16;
    localparam int DEPTH      = 100;
    localparam int STARVE_MAX = 4;
    localparam int SW         = 3;

    logic          clk, rst_n;
    logic          cpu_req, cpu_w, cpu_ready, cpu_rvalid, stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ext_req, ext_w, ext_ready, ext_rvalid;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic          err, mem_en, mem_w, dbg_resp_state;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [SW-1:0] dbg_starve_cnt;

    data_mem_arbiter #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .SW(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_w(cpu_w), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .stall(stall),
        .ext_req(ext_req), .ext_w(ext_w), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ready(ext_ready), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .err(err), .mem_en(mem_en), .mem_w(mem_w), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_resp_state(dbg_resp_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory attached to the arbiter ----------------
    logic [DW-1:0] mem_array [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_en && mem_addr < AW'(DEPTH)) begin
            if (mem_w) mem_array[mem_addr] <= mem_wdata;
            else       mem_rdata <= mem_array[mem_addr];
        end
    end

    // ---------------- checking helpers ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {cpu_ready, cpu_rvalid, stall, ext_ready, ext_rvalid,
                               err, mem_en, mem_w, dbg_resp_state}, 64'd0);
        check({tag, "_mem_bus"}, {mem_addr, mem_wdata}, 64'd0);
        check({tag, "_rdata"}, {cpu_rdata, ext_rdata}, 64'd0);
        check({tag, "_starve"}, dbg_starve_cnt, 64'd0);
    endtask

    // ---------------- reference model ----------------
    // Tracks memory contents and who must win each cycle from the arbitration
    // rules, then records the responses each accepted access must produce.
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW-1:0] cpu_exp_q[$], ext_exp_q[$];
    int            cpu_cyc_q[$], ext_cyc_q[$], err_cyc_q[$];
    int            starve_m;
    bit            cpu_pending, ext_pending;
    bit            m_e_win, m_c_win, m_w, m_in_rng;
    int            m_addr;
    logic [DW-1:0] m_wd, m_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            cpu_exp_q.delete(); ext_exp_q.delete();
            cpu_cyc_q.delete(); ext_cyc_q.delete(); err_cyc_q.delete();
            starve_m    = 0;
            cpu_pending = 0;
            ext_pending = 0;
        end else begin
            m_e_win = ext_req && (!cpu_req || starve_m >= STARVE_MAX);
            m_c_win = cpu_req && !m_e_win;
            check("starve_cnt", dbg_starve_cnt, starve_m);
            check("cpu_ready", cpu_ready, m_c_win);
            check("ext_ready", ext_ready, m_e_win);
            check("stall", stall, cpu_req && !m_c_win);
            if (m_e_win || m_c_win) begin
                m_w      = m_e_win ? ext_w : cpu_w;
                m_addr   = m_e_win ? int'(ext_addr) : int'(cpu_addr);
                m_wd     = m_e_win ? ext_wdata : cpu_wdata;
                m_in_rng = m_addr < DEPTH;
                check("mem_en", mem_en, m_in_rng);
                check("mem_w", mem_w, m_w);
                check("mem_addr", mem_addr, m_addr);
                check("mem_wdata", mem_wdata, m_wd);
                if (!m_in_rng) err_cyc_q.push_back(cyc);
                if (!m_w) begin
                    m_data = m_in_rng ? ref_mem[m_addr] : '0;
                    if (m_e_win) begin
                        ext_exp_q.push_back(m_data);
                        ext_cyc_q.push_back(cyc);
                    end else begin
                        cpu_exp_q.push_back(m_data);
                        cpu_cyc_q.push_back(cyc);
                    end
                end else if (m_in_rng) begin
                    ref_mem[m_addr] = m_wd;
                end
            end else begin
                check("mem_idle", {mem_en, mem_w, mem_addr, mem_wdata}, 64'd0);
            end
            if (ext_req && !m_e_win) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX;
            else                     starve_m = 0;
            cpu_pending = cpu_req && !m_c_win;
            ext_pending = ext_req && !m_e_win;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [DW-1:0] cpu_hold_m, ext_hold_m;
    bit            cpu_due, ext_due, err_due;

    always @(negedge clk) begin
        if (!rst_n) begin
            cpu_hold_m = '0;
            ext_hold_m = '0;
        end else begin
            cpu_due = cpu_cyc_q.size() > 0 && cpu_cyc_q[0] == cyc - 1;
            ext_due = ext_cyc_q.size() > 0 && ext_cyc_q[0] == cyc - 1;
            err_due = err_cyc_q.size() > 0 && err_cyc_q[0] == cyc - 1;
            check("resp_state", dbg_resp_state, cpu_due || ext_due);
            check("cpu_rvalid", cpu_rvalid, cpu_due);
            check("ext_rvalid", ext_rvalid, ext_due);
            check("err", err, err_due);
            if (cpu_due) begin
                cpu_hold_m = cpu_exp_q.pop_front();
                void'(cpu_cyc_q.pop_front());
            end
            if (ext_due) begin
                ext_hold_m = ext_exp_q.pop_front();
                void'(ext_cyc_q.pop_front());
            end
            if (err_due) void'(err_cyc_q.pop_front());
            check("cpu_rdata", cpu_rdata, cpu_hold_m);
            check("ext_rdata", ext_rdata, ext_hold_m);
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic c_req, input logic c_w, input logic [AW-1:0] c_a,
                         input logic [DW-1:0] c_d, input logic e_req, input logic e_w,
                         input logic [AW-1:0] e_a, input logic [DW-1:0] e_d);
        @(posedge clk);
        #1;
        cpu_req = c_req; cpu_w = c_w; cpu_addr = c_a; cpu_wdata = c_d;
        ext_req = e_req; ext_w = e_w; ext_addr = e_a; ext_wdata = e_d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return AW'($urandom_range(90, 200));
        return AW'($urandom_range(0, 15));
    endfunction

    // ---------------- stimulus ----------------
    logic          r_creq, r_ereq;

    initial begin
        rst_n = 1'b0;
        cpu_req = 0; cpu_w = 0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 0; ext_w = 0; ext_addr = '0; ext_wdata = '0;
        mem_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_array[i] = DW'(i);
            ref_mem[i]   = DW'(i);
        end
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // CPU load, no contention.
        drive(1, 0, 16'd23, '0, 0, 0, '0, '0);
        #1 check("t1_ready_same_cycle", {cpu_ready, stall}, 64'b10);
        idle(2);

        // Store then load of the same address on consecutive cycles.
        drive(1, 1, 16'd23, 16'd10, 0, 0, '0, '0);
        drive(1, 0, 16'd23, '0, 0, 0, '0, '0);
        idle(2);

        // Contention: ext must win on the fifth cycle of waiting.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, AW'(40 + i), '0, 1, 0, 16'd30, '0);
            #1 check("t3_ext_grant", {ext_ready, stall}, (i == 4) ? 64'b11 : 64'b00);
        end
        drive(1, 0, 16'd44, '0, 0, 0, '0, '0);
        #1 check("t3_starve_cleared", dbg_starve_cnt, 64'd0);
        idle(2);

        // Back-to-back loads.
        drive(1, 0, 16'd5, '0, 0, 0, '0, '0);
        drive(1, 0, 16'd6, '0, 0, 0, '0, '0);
        idle(2);

        // Out-of-range ext load.
        drive(0, 0, '0, '0, 1, 0, 16'd150, '0);
        #1 check("t5_mem_en_oor", mem_en, 64'd0);
        idle(2);

        // Reset while a load response is pending.
        drive(1, 0, 16'd40, '0, 0, 0, '0, '0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        cpu_req = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        // Random traffic; a requester that was refused keeps requesting.
        for (int n = 0; n < 500; n++) begin
            r_creq = cpu_pending || ($urandom_range(0, 2) != 0);
            r_ereq = ext_pending || ($urandom_range(0, 2) == 0);
            drive(r_creq, $urandom_range(0, 2) == 0, rand_addr(), DW'($urandom),
                  r_ereq, $urandom_range(0, 2) == 0, rand_addr(), DW'($urandom));
        end
        idle(4);
        check("queues_drained",
              cpu_cyc_q.size() + ext_cyc_q.size() + err_cyc_q.size(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port 16-bit data memory used by the Wb stage between two requesters: the CPU memory stage (LD/ST) and an external loader/debug port.
- Accepts at most one access per cycle and arbitrates with CPU priority plus a starvation guard for the external port.
- Routes registered read data back to the requester that issued the read.
- Generates the pipeline stall when the CPU access is not granted.

Parameters:
- DW, 16, data width.
- AW, 16, address width.
- DEPTH, 100, number of valid memory words; addresses >= DEPTH are out of range.
- STARVE_MAX, 4, consecutive denied ext cycles after which ext wins over CPU.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held with its fields until cpu_ready.
- cpu_w  in  1  1 = store, 0 = load.
- cpu_addr  in  AW  word address (ALU result).
- cpu_wdata  in  DW  store data (rd value).
- cpu_ready  out  1  grant; access accepted this cycle when cpu_req && cpu_ready.
- cpu_rvalid  out  1  one-cycle pulse, load data valid.
- cpu_rdata  out  DW  load data.
- stall  out  1  cpu_req && !cpu_ready.
- ext_req, ext_w, ext_addr, ext_wdata  in  1/1/AW/DW  external port, same meaning as the CPU fields.
- ext_ready, ext_rvalid  out  1  same meaning as the CPU signals.
- ext_rdata  out  DW  same meaning as cpu_rdata.
- err  out  1  one-cycle pulse, an out-of-range access was accepted in the previous cycle.
- mem_en  out  1  memory access strobe.
- mem_w  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid the cycle after mem_en && !mem_w.

Behaviour:
- Grant logic is combinational from the request inputs and state.
  - ext wins when ext_req && (!cpu_req || starve_cnt == STARVE_MAX).
  - Otherwise cpu wins when cpu_req.
  - cpu_ready and ext_ready are never both 1.
- Memory drive:
  - mem_en = grant && addr < DEPTH.
  - mem_w, mem_addr and mem_wdata are muxed from the winner.
  - With no grant, mem_en = 0 and the other memory outputs are 0.
- starve_cnt (register):
  - Cleared on reset, on an ext grant, or when ext_req = 0.
  - Incremented when ext_req && !ext_ready.
  - Saturates at STARVE_MAX.
- Read response FSM, states IDLE and RESP:
  - An accepted load registers owner (cpu/ext) and oor (out-of-range), and the FSM goes to RESP.
  - In RESP, the owner's rvalid is 1 for exactly one cycle.
  - Owner rdata = mem_rdata, or 0 if oor.
  - err = oor.
  - If a new load is accepted in the same cycle, stay in RESP (back-to-back, full throughput); otherwise return to IDLE.
- Stores produce no rvalid.
  - An out-of-range store writes nothing, and err pulses the next cycle.
- rdata hold: cpu_rdata and ext_rdata each hold their last returned value until that port's next response. Reset value 0.
- Read latency: 1 cycle from acceptance to rvalid.
  - A store followed by a load of the same address in the next cycle returns the new data.
- Simultaneous cpu and ext requests:
  - CPU granted unless starve_cnt == STARVE_MAX.
  - The loser's ready = 0 and it must hold its request; for the CPU this asserts stall.
- Reset: asynchronous, effective immediately on rst_n = 0.
  - All outputs 0, starve_cnt = 0, FSM = IDLE.
  - A pending read response is dropped, and no rvalid occurs after release.
- Request fields are sampled only in the acceptance cycle. Changes while not ready are allowed and the new value is used.

Test Plan:
1. Memory preloaded with data_mem[i] = i. CPU load from addr 23, no ext request -> cpu_ready = 1 in the same cycle, stall = 0; next cycle cpu_rvalid = 1 with cpu_rdata = 23; ext_rvalid stays 0.
2. CPU store of 10 to addr 23, then CPU load from addr 23 in the next cycle -> mem_w = 1 with mem_wdata = 10 in cycle 1; cpu_rdata = 10 in cycle 3; no rvalid for the store.
3. cpu_req and ext_req held continuously, ext reading addr 30 -> CPU granted for 4 cycles, ext granted in cycle 5 with stall = 1 that cycle; ext_rdata = 30 in cycle 6; starve_cnt back to 0 after the grant.
4. Back-to-back CPU loads of addr 5 then addr 6 -> rvalid high for 2 consecutive cycles with data 5 then 6; FSM stays in RESP.
5. ext load from addr 150 (DEPTH = 100) -> mem_en = 0; next cycle ext_rvalid = 1 with ext_rdata = 0 and err = 1.
6. Drive rst_n = 0 in the cycle after a CPU load is accepted -> all outputs 0 immediately; no cpu_rvalid after rst_n returns to 1; cpu_rdata = 0.
